vector_store_unit: RTL and testbench

Sequential write-back engine for the custom vector extension. It accepts one packed result vector (VECTOR_LENGTH elements of DATA_WIDTH bits) via a valid/ready handshake. It then stores the active elements one word at a time to the data-memory port, starting at a base address and advancing by a signed byte stride. It sits between the combinational vector ALU output and the core's data-memory interface, and is the store-side counterpart to the vector datapath.

---
 rtl/vector_store_unit.sv | 136 +++++++++++++
 tb/tb_vector_store_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vector_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : vector_store_unit
// Description : Write-back engine for one packed result vector. It latches the
//               vector, base address, signed byte stride and clamped length,
//               then writes the active elements one word at a time to the
//               data-memory port, holding each request until it is acked.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_store_unit #(
  parameter  int VECTOR_LENGTH = 8,
  parameter  int DATA_WIDTH    = 32,
  parameter  int ADDR_WIDTH    = 32,
  localparam int VL_W          = $clog2(VECTOR_LENGTH + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start_valid,
  output logic                                start_ready,
  input  logic [VECTOR_LENGTH*DATA_WIDTH-1:0] vector_data,
  input  logic [ADDR_WIDTH-1:0]               base_addr,
  input  logic [ADDR_WIDTH-1:0]               stride,
  input  logic [VL_W-1:0]                     vl,
  output logic                                mem_req,
  output logic                                mem_we,
  output logic [ADDR_WIDTH-1:0]               mem_addr,
  output logic [DATA_WIDTH-1:0]               mem_wdata,
  input  logic                                mem_ack,
  output logic                                busy,
  output logic                                done
);

  localparam int IDX_W = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_WRITE = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  localparam logic [VL_W-1:0] c_VLEN = VL_W'(VECTOR_LENGTH);
  localparam logic [VL_W-1:0] c_ONE  = VL_W'(1);

  logic [1:0]            state_q, state_d;
  logic [VL_W-1:0]       idx_q, idx_d;
  logic [VL_W-1:0]       effvl_q, effvl_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [DATA_WIDTH-1:0] elem_q [VECTOR_LENGTH];

  logic                  accept_w;
  logic                  last_w;
  logic [VL_W-1:0]       vl_clamp_w;

  assign accept_w   = (state_q == c_IDLE) && start_valid;
  // Requests longer than the vector are clamped to the full vector.
  assign vl_clamp_w = (vl > c_VLEN) ? c_VLEN : vl;
  // Only meaningful in WRITE, where effvl_q is at least one.
  assign last_w     = (idx_q == (effvl_q - c_ONE));

  // Next-state and datapath update for the store sequencer.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    effvl_d  = effvl_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    case (state_q)
      c_IDLE: begin
        if (accept_w) begin
          effvl_d  = vl_clamp_w;
          stride_d = stride;
          addr_d   = base_addr;
          idx_d    = '0;
          state_d  = (vl_clamp_w == '0) ? c_DONE : c_WRITE;
        end
      end
      c_WRITE: begin
        if (mem_ack) begin
          if (last_w) begin
            state_d = c_DONE;
          end else begin
            idx_d  = idx_q + c_ONE;
            // Modulo 2^ADDR_WIDTH: a negative stride simply walks downward.
            addr_d = addr_q + stride_q;
          end
        end
      end
      c_DONE: begin
        state_d = c_IDLE;
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  // Control and address registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= c_IDLE;
      idx_q    <= '0;
      effvl_q  <= '0;
      addr_q   <= '0;
      stride_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      effvl_q  <= effvl_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
    end
  end

  // Snapshot of the vector at acceptance so later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < VECTOR_LENGTH; i++) begin
        elem_q[i] <= '0;
      end
    end else if (accept_w) begin
      for (int i = 0; i < VECTOR_LENGTH; i++) begin
        elem_q[i] <= vector_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Outputs decode registered state only; address/data read zero outside WRITE.
  assign start_ready = (state_q == c_IDLE);
  assign busy        = (state_q == c_WRITE) || (state_q == c_DONE);
  assign done        = (state_q == c_DONE);
  assign mem_req     = (state_q == c_WRITE);
  assign mem_we      = mem_req;
  assign mem_addr    = mem_req ? addr_q : '0;
  assign mem_wdata   = mem_req ? elem_q[idx_q[IDX_W-1:0]] : '0;

endmodule
`default_nettype wire

// File: tb/tb_vector_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_store_unit
// Description : Directed self-checking bench for vector_store_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_store_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [255:0] vector_data;
  logic [31:0]  base_addr;
  logic [31:0]  stride;
  logic [3:0]   vl;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ack;
  logic         busy;
  logic         done;

  int n_pass  = 0;
  int n_total = 0;

  logic [255:0] vec_a;
  logic [255:0] vec_b;

  vector_store_unit #(
    .VECTOR_LENGTH(8),
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .vector_data(vector_data),
    .base_addr  (base_addr),
    .stride     (stride),
    .vl         (vl),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Idle/reset output values.
  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 32'(start_ready), 32'd1);
    chk({tag, "_busy"},  32'(busy),        32'd0);
    chk({tag, "_done"},  32'(done),        32'd0);
    chk({tag, "_req"},   32'(mem_req),     32'd0);
    chk({tag, "_we"},    32'(mem_we),      32'd0);
    chk({tag, "_addr"},  mem_addr,         32'd0);
    chk({tag, "_wdata"}, mem_wdata,        32'd0);
  endtask

  // Full store with mem_ack high; inputs are scrambled after acceptance.
  task automatic do_store(input string tag, input logic [255:0] v, input logic [31:0] b,
                          input logic [31:0] s, input logic [3:0] l, input int n);
    logic [31:0] ea;
    start_valid = 1'b1;
    vector_data = v;
    base_addr   = b;
    stride      = s;
    vl          = l;
    chk({tag, "_ready0"}, 32'(start_ready), 32'd1);
    tick();
    start_valid = 1'b0;
    vector_data = ~v;
    base_addr   = 32'hDEAD_BEEF;
    stride      = 32'h0000_0100;
    vl          = 4'd1;
    for (int k = 0; k < n; k++) begin
      ea = b + 32'(k) * s;
      chk($sformatf("%s_req%0d", tag, k),  32'(mem_req & mem_we), 32'd1);
      chk($sformatf("%s_addr%0d", tag, k), mem_addr, ea);
      chk($sformatf("%s_data%0d", tag, k), mem_wdata, v[k*32 +: 32]);
      chk($sformatf("%s_busy%0d", tag, k), 32'(busy & ~start_ready), 32'd1);
      tick();
    end
    chk({tag, "_done"},    32'(done),    32'd1);
    chk({tag, "_donereq"}, 32'(mem_req), 32'd0);
    chk({tag, "_donerdy"}, 32'(start_ready), 32'd0);
    tick();
    chk({tag, "_done_off"}, 32'(done),        32'd0);
    chk({tag, "_ready_on"}, 32'(start_ready), 32'd1);
  endtask

  initial begin
    int ei;
    vec_a = {32'h88, 32'h77, 32'h66, 32'h55, 32'h44, 32'h33, 32'h22, 32'h11};
    vec_b = {32'hB8, 32'hB7, 32'hB6, 32'hB5, 32'hB4, 32'hB3, 32'hB2, 32'hB1};
    rst         = 1'b1;
    start_valid = 1'b0;
    vector_data = '0;
    base_addr   = '0;
    stride      = '0;
    vl          = '0;
    mem_ack     = 1'b1;
    #1;
    chk_idle("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_idle("post_reset");

    // Basic store: 8 writes 0x1000..0x101C, done in cycle 9, ready in 10.
    do_store("basic", vec_a, 32'h1000, 32'd4, 4'd8, 8);

    // Partial length and clamping.
    do_store("vl3",  vec_a, 32'h0100, 32'd4, 4'd3, 3);
    do_store("vl15", vec_a, 32'h0200, 32'd4, 4'd15, 8);
    do_store("vl0",  vec_a, 32'h0300, 32'd4, 4'd0, 0);

    // Negative stride with wrap: hand-computed addresses 0x4, 0x0, 0xFFFFFFFC.
    start_valid = 1'b1;
    vector_data = vec_b;
    base_addr   = 32'h4;
    stride      = 32'hFFFF_FFFC;
    vl          = 4'd3;
    tick();
    start_valid = 1'b0;
    chk("neg_addr0", mem_addr, 32'h0000_0004);
    tick();
    chk("neg_addr1", mem_addr, 32'h0000_0000);
    tick();
    chk("neg_addr2", mem_addr, 32'hFFFF_FFFC);
    chk("neg_data2", mem_wdata, 32'hB3);
    tick();
    chk("neg_done", 32'(done), 32'd1);
    tick();

    // Stride 0: every element to the same address, in index order.
    do_store("stride0", vec_b, 32'h0000_0040, 32'd0, 4'd4, 4);

    // Backpressure: ack low in cycles 3..5 while element 2 is presented.
    start_valid = 1'b1;
    vector_data = vec_a;
    base_addr   = 32'h2000;
    stride      = 32'd8;
    vl          = 4'd8;
    tick();
    start_valid = 1'b0;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      mem_ack = (cyc >= 3 && cyc <= 5) ? 1'b0 : 1'b1;
      ei = (cyc <= 2) ? cyc - 1 : ((cyc <= 6) ? 2 : cyc - 4);
      chk($sformatf("bp_req_c%0d", cyc),  32'(mem_req), 32'd1);
      chk($sformatf("bp_addr_c%0d", cyc), mem_addr, 32'h2000 + 32'(ei) * 32'd8);
      chk($sformatf("bp_data_c%0d", cyc), mem_wdata, vec_a[ei*32 +: 32]);
      tick();
    end
    mem_ack = 1'b1;
    chk("bp_done_c12", 32'(done), 32'd1);
    tick();
    chk("bp_ready_c13", 32'(start_ready), 32'd1);

    // Busy protection: a second request is held during the first store.
    start_valid = 1'b1;
    vector_data = vec_a;
    base_addr   = 32'h3000;
    stride      = 32'd4;
    vl          = 4'd4;
    tick();
    vector_data = vec_b;
    base_addr   = 32'h5000;
    stride      = 32'd16;
    vl          = 4'd2;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("busy_rdy%0d", k),  32'(start_ready), 32'd0);
      chk($sformatf("busy_addr%0d", k), mem_addr, 32'h3000 + 32'(k) * 32'd4);
      chk($sformatf("busy_data%0d", k), mem_wdata, vec_a[k*32 +: 32]);
      tick();
    end
    chk("busy_done",    32'(done),        32'd1);
    chk("busy_donerdy", 32'(start_ready), 32'd0);
    tick();
    chk("busy_rdy_again", 32'(start_ready), 32'd1);
    tick();
    start_valid = 1'b0;
    chk("second_addr0", mem_addr,  32'h5000);
    chk("second_data0", mem_wdata, 32'hB1);
    tick();
    chk("second_addr1", mem_addr,  32'h5010);
    chk("second_data1", mem_wdata, 32'hB2);
    tick();
    chk("second_done", 32'(done), 32'd1);
    tick();

    // Reset during element 4 of 8: outputs clear without waiting for a clock.
    start_valid = 1'b1;
    vector_data = vec_a;
    base_addr   = 32'h6000;
    stride      = 32'd4;
    vl          = 4'd8;
    tick();
    start_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("pre_rst_addr4", mem_addr, 32'h6010);
    rst = 1'b1;
    #1;
    chk_idle("async_rst");
    tick();
    rst = 1'b0;
    tick();
    chk_idle("after_rst");
    tick();
    chk("after_rst_noreq", 32'(mem_req), 32'd0);
    do_store("post_rst", vec_b, 32'h7000, 32'd4, 4'd8, 8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
